// File: rtl/spi_status_display.sv
// SPI-slaved status display: receives state frames, runs the system-state FSM and drives
// a bicolour bargraph plus result LEDs. Define SPI_WATCHDOG_EN to add a lost-master watchdog.
module spi_status_display #(
  parameter int unsigned BAR_W       = 4,
  parameter int unsigned N_RES       = 4,
  parameter int unsigned RES_W       = 3,
  parameter int unsigned SWEEP_DIV   = 22,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDOG_W      = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             cs_n,
  output logic             sdo,
  input  logic [RES_W-1:0] result,
  output logic             frame_valid,
  output logic [2:0]       sys_state,
  output logic [BAR_W-1:0] bar_R,
  output logic [BAR_W-1:0] bar_G,
  output logic             led_rdy,
  output logic             led_rec,
  output logic [N_RES-1:0] led_res,
  output logic             fail
);

  localparam int unsigned IdxW = (BAR_W > 2) ? $clog2(BAR_W) : 1;

  typedef enum logic [2:0] {
    StReady   = 3'd1,
    StListen  = 3'd2,
    StProcess = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
  logic                   sck_s, sdi_s, cs_s;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_rise, sck_fall, cs_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // ---------------------------------------------------------------------------
  // SPI shift logic
  // ---------------------------------------------------------------------------
  logic [RES_W-1:0] res_lat_q, res_lat_d;
  logic             have_result_q, have_result_d;
  logic             fail_q, fail_d;
  logic [2:0]       res_lo;

  if (RES_W >= 3) begin : gen_res_lo_trunc
    assign res_lo = res_lat_q[2:0];
  end else begin : gen_res_lo_ext
    assign res_lo = {{(3 - RES_W){1'b0}}, res_lat_q};
  end

  // Only the last three received bits decide a frame, so only those are kept.
  logic [1:0] rx_q, rx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_q, tx_d;
  logic       sdo_q, sdo_d;
  logic       accept;
  logic [2:0] code;
  logic       frame_valid_q;

  always_comb begin
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    sdo_d     = sdo_q;
    accept    = 1'b0;
    code      = {rx_q, sdi_s};
    if (cs_s) begin
      sdo_d     = 1'b0;
      bit_cnt_d = '0;
    end else if (cs_fall) begin
      tx_d      = {2'b00, res_lo, state_q};
      bit_cnt_d = '0;
      sdo_d     = tx_d[7];
    end else begin
      if (sck_rise) begin
        rx_d      = {rx_q[0], sdi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7 && code >= 3'd1 && code <= 3'd4) begin
          accept = 1'b1;
        end
      end
      if (sck_fall) begin
        tx_d  = {tx_q[6:0], 1'b0};
        sdo_d = tx_q[6];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q          <= '0;
      bit_cnt_q     <= '0;
      tx_q          <= '0;
      sdo_q         <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      rx_q          <= rx_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_q          <= tx_d;
      sdo_q         <= sdo_d;
      frame_valid_q <= accept;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional lost-master watchdog
  // ---------------------------------------------------------------------------
  logic active;
  assign active = (state_q == StListen) || (state_q == StProcess);

`ifdef SPI_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_expired;

  assign wdog_expired = active && (&wdog_q);

  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if (!active || frame_valid_q || wdog_expired) begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic wdog_expired;
  assign wdog_expired = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // System-state FSM and result latch
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    res_lat_d     = res_lat_q;
    have_result_d = have_result_q;
    fail_d        = fail_q;
    if (accept) begin
      state_d = state_e'(code);
      if (code == 3'd4 && state_q != StDone) begin
        res_lat_d     = result;
        have_result_d = 1'b1;
        fail_d        = (result == '0);
      end
    end else if (wdog_expired) begin
      // A silent master is reported as a failed result.
      state_d       = StReady;
      res_lat_d     = '0;
      have_result_d = 1'b1;
      fail_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StReady;
      res_lat_q     <= '0;
      have_result_q <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      res_lat_q     <= res_lat_d;
      have_result_q <= have_result_d;
      fail_q        <= fail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PROCESS sweep: bouncing index, restarted at 0 on every PROCESS entry
  // ---------------------------------------------------------------------------
  logic [SWEEP_DIV-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 dir_down_q, dir_down_d;

  always_comb begin
    sweep_cnt_d = sweep_cnt_q + 1'b1;
    idx_d       = idx_q;
    dir_down_d  = dir_down_q;
    if (state_q != StProcess) begin
      sweep_cnt_d = '0;
      idx_d       = '0;
      dir_down_d  = 1'b0;
    end else if (&sweep_cnt_q) begin
      if (!dir_down_q) begin
        if (idx_q == IdxW'(BAR_W - 1)) begin
          idx_d      = IdxW'(BAR_W - 2);
          dir_down_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          idx_d      = IdxW'(1);
          dir_down_d = 1'b0;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sweep_cnt_q <= '0;
      idx_q       <= '0;
      dir_down_q  <= 1'b0;
    end else begin
      sweep_cnt_q <= sweep_cnt_d;
      idx_q       <= idx_d;
      dir_down_q  <= dir_down_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display decode, registered
  // ---------------------------------------------------------------------------
  logic [BAR_W-1:0] bar_r_q, bar_r_d, bar_g_q, bar_g_d;
  logic             led_rdy_q, led_rdy_d, led_rec_q, led_rec_d;
  logic [N_RES-1:0] led_res_q, led_res_d, res_dec;
  logic             fail_out_q;

  always_comb begin
    res_dec = '0;
    for (int k = 1; k <= int'(N_RES); k++) begin
      res_dec[k-1] = have_result_q && (32'(res_lat_q) == 32'(k));
    end
  end

  always_comb begin
    bar_r_d   = '0;
    bar_g_d   = '0;
    led_rdy_d = 1'b0;
    led_rec_d = 1'b0;
    led_res_d = '0;
    unique case (state_q)
      StReady: begin
        led_rdy_d = 1'b1;
        led_res_d = res_dec;
        if (have_result_q && fail_q) bar_r_d = '1;
        else                         bar_g_d = '1;
      end
      StListen: begin
        led_rec_d = 1'b1;
        bar_r_d   = '1;
        led_res_d = '1;
      end
      StProcess: begin
        bar_r_d   = BAR_W'(1) << idx_q;
        led_res_d = '1;
      end
      StDone: begin
        bar_g_d   = '1;
        led_res_d = res_dec;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bar_r_q    <= '0;
      bar_g_q    <= '1;
      led_rdy_q  <= 1'b1;
      led_rec_q  <= 1'b0;
      led_res_q  <= '0;
      fail_out_q <= 1'b0;
    end else begin
      bar_r_q    <= bar_r_d;
      bar_g_q    <= bar_g_d;
      led_rdy_q  <= led_rdy_d;
      led_rec_q  <= led_rec_d;
      led_res_q  <= led_res_d;
      fail_out_q <= fail_q;
    end
  end

  assign sdo         = sdo_q;
  assign frame_valid = frame_valid_q;
  assign sys_state   = state_q;
  assign bar_R       = bar_r_q;
  assign bar_G       = bar_g_q;
  assign led_rdy     = led_rdy_q;
  assign led_rec     = led_rec_q;
  assign led_res     = led_res_q;
  assign fail        = fail_out_q;

endmodule

// File: tb/tb_spi_status_display.sv
// Self-checking bench for spi_status_display: SPI master model with a scoreboard of
// expected state codes popped on each frame_valid pulse.
module tb_spi_status_display;

  localparam int unsigned BAR_W       = 4;
  localparam int unsigned N_RES       = 4;
  localparam int unsigned RES_W       = 3;
  localparam int unsigned SWEEP_DIV   = 2;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned WDOG_W      = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sck = 1'b0;
  logic             sdi = 1'b0;
  logic             cs_n = 1'b1;
  logic             sdo;
  logic [RES_W-1:0] result = '0;
  logic             frame_valid;
  logic [2:0]       sys_state;
  logic [BAR_W-1:0] bar_R, bar_G;
  logic             led_rdy, led_rec;
  logic [N_RES-1:0] led_res;
  logic             fail;

  spi_status_display #(
    .BAR_W      (BAR_W),
    .N_RES      (N_RES),
    .RES_W      (RES_W),
    .SWEEP_DIV  (SWEEP_DIV),
    .SYNC_STAGES(SYNC_STAGES),
    .WDOG_W     (WDOG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .cs_n       (cs_n),
    .sdo        (sdo),
    .result     (result),
    .frame_valid(frame_valid),
    .sys_state  (sys_state),
    .bar_R      (bar_R),
    .bar_G      (bar_G),
    .led_rdy    (led_rdy),
    .led_rec    (led_rec),
    .led_res    (led_res),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [2:0]       exp_q[$];
  logic [BAR_W-1:0] rec_q[$];
  bit               rec_en = 1'b0;
  logic [2:0]       prev_state = 3'd0;
  int               fv_count = 0;

  // Scoreboard pop on frame_valid, plus bar_R capture while settled in PROCESS.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_valid) begin
        fv_count++;
        if (exp_q.size() == 0) check("unexpected_frame_valid", 32'(frame_valid), 32'd0);
        else check("frame_state", 32'(sys_state), 32'(exp_q.pop_front()));
      end
      if (rec_en && sys_state == 3'd3 && prev_state == 3'd3 && rec_q.size() < 28)
        rec_q.push_back(bar_R);
      prev_state = sys_state;
    end
  end

  // sck period 100 ns = 10 clk cycles.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    if (nbits == 8 && tx[2:0] >= 3'd1 && tx[2:0] <= 3'd4) exp_q.push_back(tx[2:0]);
    cs_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7-i];
      #50;
      sck = 1'b1;
      rx = {rx[6:0], sdo};
      #50;
      sck = 1'b0;
    end
    #50;
    cs_n = 1'b1;
    sdi  = 1'b0;
    #60;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    logic [3:0] e;
    int         base;
    int         seq[6];
    seq = '{0, 1, 2, 3, 2, 1};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(sys_state), 32'd1);
    check("rst_led_rdy", 32'(led_rdy), 32'd1);
    check("rst_led_rec", 32'(led_rec), 32'd0);
    check("rst_bar_G", 32'(bar_G), 32'hf);
    check("rst_bar_R", 32'(bar_R), 32'h0);
    check("rst_led_res", 32'(led_res), 32'h0);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);

    // LISTEN
    base = fv_count;
    spi_xfer(8'h02, 8, rx);
    @(negedge clk);
    check("listen_pulses", 32'(fv_count - base), 32'd1);
    check("listen_state", 32'(sys_state), 32'd2);
    check("listen_led_rec", 32'(led_rec), 32'd1);
    check("listen_led_rdy", 32'(led_rdy), 32'd0);
    check("listen_bar_R", 32'(bar_R), 32'hf);
    check("listen_bar_G", 32'(bar_G), 32'h0);
    check("listen_led_res", 32'(led_res), 32'hf);

`ifndef SPI_WATCHDOG_EN
    // PROCESS sweep
    rec_en = 1'b1;
    spi_xfer(8'h03, 8, rx);
    for (int t = 0; t < 200 && rec_q.size() < 28; t++) @(negedge clk);
    rec_en = 1'b0;
    check("sweep_samples", 32'(rec_q.size()), 32'd28);
    for (int j = 0; j < rec_q.size(); j++) begin
      e = 4'b0001 << seq[(j / 4) % 6];
      check($sformatf("sweep_%0d", j), 32'(rec_q[j]), 32'(e));
    end
    check("process_bar_G", 32'(bar_G), 32'h0);
    check("process_led_res", 32'(led_res), 32'hf);
`endif

    // DONE then READY with result 3
    result = 3'd3;
    spi_xfer(8'h04, 8, rx);
    @(negedge clk);
    check("done_state", 32'(sys_state), 32'd4);
    check("done_bar_G", 32'(bar_G), 32'hf);
    check("done_bar_R", 32'(bar_R), 32'h0);
    check("done_led_res", 32'(led_res), 32'h4);
    spi_xfer(8'h01, 8, rx);
    @(negedge clk);
    check("ready_state", 32'(sys_state), 32'd1);
    check("ready_led_rdy", 32'(led_rdy), 32'd1);
    check("ready_led_res", 32'(led_res), 32'h4);
    check("ready_fail", 32'(fail), 32'd0);
    check("ready_bar_G", 32'(bar_G), 32'hf);

    // Invalid code 7 is ignored; returned byte carries res_lat and state
    base = fv_count;
    spi_xfer(8'h07, 8, rx);
    @(negedge clk);
    check("status_byte", 32'(rx), 32'h19);
    check("ignored_pulses", 32'(fv_count - base), 32'd0);
    check("ignored_state", 32'(sys_state), 32'd1);

    // Failed result
    result = 3'd0;
    spi_xfer(8'h04, 8, rx);
    spi_xfer(8'h01, 8, rx);
    @(negedge clk);
    check("failres_fail", 32'(fail), 32'd1);
    check("failres_bar_R", 32'(bar_R), 32'hf);
    check("failres_bar_G", 32'(bar_G), 32'h0);
    check("failres_led_res", 32'(led_res), 32'h0);

    // Partial frame discarded, next full frame realigned
    base = fv_count;
    spi_xfer(8'hA5, 5, rx);
    @(negedge clk);
    check("partial_pulses", 32'(fv_count - base), 32'd0);
    check("partial_state", 32'(sys_state), 32'd1);
    spi_xfer(8'h02, 8, rx);
    @(negedge clk);
    check("realign_status_byte", 32'(rx), 32'h01);
    check("realign_state", 32'(sys_state), 32'd2);
    check("realign_pulses", 32'(fv_count - base), 32'd1);

`ifdef SPI_WATCHDOG_EN
    repeat (20) @(negedge clk);
    check("wdog_state", 32'(sys_state), 32'd1);
    check("wdog_fail", 32'(fail), 32'd1);
    check("wdog_bar_R", 32'(bar_R), 32'hf);
`else
    repeat (40) @(negedge clk);
    check("nowdog_state", 32'(sys_state), 32'd2);
    check("nowdog_led_rec", 32'(led_rec), 32'd1);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
